// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the Yu Core instruction fetch stage.
package instr_fetch_unit_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StWait  = 3'd2,
        StHold  = 3'd3,
        StError = 3'd4
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NopInstr       = 32'h0000_0013;
    localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_pc_next.sv
// Next-PC arithmetic: sequential and branch targets plus word-alignment check.
module instr_fetch_unit_pc_next #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm_ext,
    input  logic            i_pc_src,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic [XLEN-1:0] o_target,
    output logic            o_misaligned
);

    logic [XLEN-1:0] w_branch_target;

    // Both adds wrap modulo 2^XLEN; wrapping to 0 is a legal aligned target.
    assign o_pc_plus4      = i_pc + XLEN'(4);
    assign w_branch_target = i_pc + i_imm_ext;
    assign o_target        = i_pc_src ? w_branch_target : o_pc_plus4;
    assign o_misaligned    = |o_target[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Stallable fetch front end: owns the PC, handshakes with instruction memory,
// and holds each fetched word for the core until it is retired.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(ResetPcDefault)
) (
    input  logic            clk,
    input  logic            resetN,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemReady,
    input  logic            imemValid,
    input  logic [XLEN-1:0] imemRdata,
    output logic            instrValid,
    input  logic            instrReady,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] immExt,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic            funct7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4,
    output logic            fetchErr
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] w_target;
    logic            w_misaligned;
    logic            w_capture;
    logic            w_pc_load;

    instr_fetch_unit_pc_next #(
        .XLEN (XLEN)
    ) u_pc_next (
        .i_pc         (r_pc),
        .i_imm_ext    (immExt),
        .i_pc_src     (PCSrc),
        .o_pc_plus4   (pcPlus4),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_pc_load    = 1'b0;
        unique case (r_state)
            StIdle: w_state_next = StReq;
            StReq: begin
                if (imemReady) begin
                    if (imemValid) begin
                        w_capture    = 1'b1;
                        w_state_next = StHold;
                    end else begin
                        w_state_next = StWait;
                    end
                end
            end
            StWait: begin
                if (imemValid) begin
                    w_capture    = 1'b1;
                    w_state_next = StHold;
                end
            end
            StHold: begin
                if (instrReady) begin
                    if (w_misaligned) begin
                        w_state_next = StError;
                    end else begin
                        w_pc_load    = 1'b1;
                        w_state_next = StReq;
                    end
                end
            end
            StError: w_state_next = StError;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= StIdle;
            r_pc    <= RESET_PC;
            r_instr <= XLEN'(NopInstr);
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_instr <= imemRdata;
            end
            if (w_pc_load) begin
                r_pc <= w_target;
            end
        end
    end

    // Handshake outputs come straight from the state register: no input-to-output paths.
    assign imemReq    = (r_state == StReq);
    assign instrValid = (r_state == StHold);
    assign fetchErr   = (r_state == StError);
    assign imemAddr   = r_pc;
    assign pc         = r_pc;
    assign instr      = r_instr;
    assign opcode     = r_instr[6:0];
    assign funct3     = r_instr[14:12];
    assign funct7     = r_instr[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a pc/word scoreboard.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetN;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemValid;
    logic [31:0] imemRdata;
    logic        instrValid;
    logic        instrReady;
    logic        PCSrc;
    logic [31:0] immExt;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        fetchErr;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemReady  (imemReady),
        .imemValid  (imemValid),
        .imemRdata  (imemRdata),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .PCSrc      (PCSrc),
        .immExt     (immExt),
        .instr      (instr),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .pc         (pc),
        .pcPlus4    (pcPlus4),
        .fetchErr   (fetchErr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Serve one fetch: ready_wait cycles of imemReady=0, then respond valid_wait cycles after accept.
    task automatic fetch(input int ready_wait, input int valid_wait, input logic [31:0] word);
        int guard = 0;
        while (imemReq !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_bit("req_seen", imemReq, 1'b1);
        check("imem_addr", imemAddr, model_pc);
        for (int i = 0; i < ready_wait; i++) begin
            imemReady = 1'b0;
            @(negedge clk);
            check_bit("req_held", imemReq, 1'b1);
            check("addr_held", imemAddr, model_pc);
        end
        imemReady = 1'b1;
        if (valid_wait == 0) begin
            imemValid = 1'b1;
            imemRdata = word;
            @(negedge clk);
        end else begin
            imemValid = 1'b0;
            @(negedge clk);
            imemReady = 1'b0;
            check_bit("wait_no_req", imemReq, 1'b0);
            for (int i = 0; i < valid_wait - 1; i++) begin
                @(negedge clk);
                check_bit("wait_not_valid", instrValid, 1'b0);
            end
            imemValid = 1'b1;
            imemRdata = word;
            @(negedge clk);
        end
        imemReady = 1'b0;
        imemValid = 1'b0;
        imemRdata = $urandom;
        sb.push_back('{pc: model_pc, word: word});
        check_bit("instr_valid_rise", instrValid, 1'b1);
    endtask

    // Retire the held instruction after stall cycles of backpressure.
    task automatic retire(input logic pcsrc, input logic [31:0] imm, input int stall);
        exp_t        e;
        logic [31:0] tgt;
        check_bit("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check_bit("hold_valid", instrValid, 1'b1);
        check("instr", instr, e.word);
        check("pc", pc, e.pc);
        check("opcode", {25'b0, opcode}, {25'b0, e.word[6:0]});
        check("funct3", {29'b0, funct3}, {29'b0, e.word[14:12]});
        check_bit("funct7", funct7, e.word[30]);
        check("pc_plus4", pcPlus4, e.pc + 32'd4);
        check_bit("no_err", fetchErr, 1'b0);
        for (int i = 0; i < stall; i++) begin
            instrReady = 1'b0;
            PCSrc      = 1'(i);
            immExt     = $urandom;
            @(negedge clk);
            check("stall_instr", instr, e.word);
            check("stall_pc", pc, e.pc);
            check_bit("stall_no_req", imemReq, 1'b0);
            check_bit("stall_valid", instrValid, 1'b1);
        end
        instrReady = 1'b1;
        PCSrc      = pcsrc;
        immExt     = imm;
        @(negedge clk);
        instrReady = 1'b0;
        PCSrc      = 1'b1;
        immExt     = 32'h0000_0001;
        tgt = pcsrc ? e.pc + imm : e.pc + 32'd4;
        if (tgt[1:0] != 2'b00) begin
            check_bit("err_set", fetchErr, 1'b1);
            check_bit("err_no_valid", instrValid, 1'b0);
            check_bit("err_no_req", imemReq, 1'b0);
            check("err_pc_kept", pc, e.pc);
        end else begin
            model_pc = tgt;
            check_bit("next_req", imemReq, 1'b1);
            check("next_addr", imemAddr, tgt);
            check("next_pc", pc, tgt);
            check_bit("next_no_err", fetchErr, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] words[4];
        int          guard;
        words[0] = 32'h0050_0093;
        words[1] = 32'h4020_5233;
        words[2] = 32'h0000_2303;
        words[3] = 32'h0080_0063;

        resetN     = 1'b0;
        imemReady  = 1'b0;
        imemValid  = 1'b0;
        imemRdata  = 32'h0;
        instrReady = 1'b0;
        PCSrc      = 1'b0;
        immExt     = 32'h0;
        model_pc   = 32'h0;
        repeat (2) @(negedge clk);

        check_bit("rst_req", imemReq, 1'b0);
        check_bit("rst_valid", instrValid, 1'b0);
        check_bit("rst_err", fetchErr, 1'b0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, NopInstr);

        resetN = 1'b1;
        check_bit("idle_no_req", imemReq, 1'b0);
        @(negedge clk);
        check_bit("first_req", imemReq, 1'b1);

        // Sequential zero-wait fetches 0, 4, 8, 12.
        for (int i = 0; i < 4; i++) begin
            fetch(0, 0, words[i]);
            retire(1'b0, 32'h0, 0);
        end

        // Branches: 0x10 - 8 -> 0x08, then 0x08 + 8 -> 0x10, then 0x10 + 0x20 -> 0x30.
        fetch(0, 0, 32'h1234_5013);
        retire(1'b1, 32'hFFFF_FFF8, 0);
        fetch(0, 0, 32'h0000_1067);
        retire(1'b1, 32'h0000_0008, 0);
        fetch(0, 0, 32'h4000_7033);
        retire(1'b1, 32'h0000_0020, 0);

        // Memory latency plus backpressure with toggling PCSrc.
        fetch(3, 2, 32'hC0F0_60B3);
        retire(1'b0, 32'h0, 5);

        // Wrap from 0xFFFF_FFFC to 0 with no error.
        fetch(0, 0, 32'h0000_0013);
        retire(1'b1, 32'hFFFF_FFC8, 0);
        fetch(1, 1, 32'h4AB0_3F83);
        retire(1'b0, 32'h0, 0);
        fetch(0, 0, 32'h0020_8133);
        retire(1'b0, 32'h0, 0);

        // Misaligned branch target: 4 + 2.
        fetch(0, 0, 32'h0040_0463);
        retire(1'b1, 32'h0000_0002, 0);
        imemReady = 1'b1;
        imemValid = 1'b1;
        imemRdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_bit("err_sticky", fetchErr, 1'b1);
            check_bit("err_req_low", imemReq, 1'b0);
            check("err_instr_kept", instr, 32'h0040_0463);
        end
        imemReady = 1'b0;
        imemValid = 1'b0;

        // Reset out of ERROR, then reset in WAIT with a late response.
        resetN = 1'b0;
        @(negedge clk);
        check_bit("err_cleared", fetchErr, 1'b0);
        resetN   = 1'b1;
        model_pc = 32'h0;
        sb.delete();
        guard = 0;
        while (imemReq !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_bit("req_after_rst", imemReq, 1'b1);
        imemReady = 1'b1;
        imemValid = 1'b0;
        @(negedge clk);
        imemReady = 1'b0;
        check_bit("in_wait", imemReq, 1'b0);
        #2;
        resetN = 1'b0;
        #1;
        check("wait_rst_pc", pc, 32'h0);
        check("wait_rst_instr", instr, NopInstr);
        check_bit("wait_rst_req", imemReq, 1'b0);
        check_bit("wait_rst_valid", instrValid, 1'b0);
        imemValid = 1'b1;
        imemRdata = 32'hBAD0_0BAD;
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        imemValid = 1'b0;
        check("stale_dropped", instr, NopInstr);
        check_bit("stale_no_valid", instrValid, 1'b0);
        check_bit("post_rst_req", imemReq, 1'b1);
        fetch(0, 0, 32'h0011_0113);
        retire(1'b0, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
